// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the frame FSM state encoding and a frame-length helper.
package fifo_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int frame_len(input int clks_per_bit, input int parity_en,
                                   input int stop_bits);
    return clks_per_bit * (1 + DATA_BITS + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 after a clear and holds at the
// terminal count, flagging bit_tick there until the next clear.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != TERM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and sends them as start/data/parity/stop
// frames on a registered tx line.
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a non-empty FIFO
// POP    | read strobe high for one cycle
// LATCH  | capture FIFO read data and its parity
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (only when PARITY_EN)
// STOP   | STOP_BITS stop bits, frame_done in the last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  tx_state_e            state, state_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 parity, parity_nxt;
  logic                 tx_nxt;
  logic                 bit_tick;
  logic                 baud_clr;
  logic                 start_ok;

  assign start_ok = tx_en && !fifo_empty;
  assign busy     = (state != IDLE);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    parity_nxt  = parity;
    frame_done  = 1'b0;
    tx_nxt      = 1'b1;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = POP;
      end
      POP: state_nxt = LATCH;
      LATCH: begin
        shift_nxt  = fifo_data;
        parity_nxt = ^fifo_data;
        state_nxt  = START;
      end
      START: begin
        if (bit_tick) begin
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            if (PARITY_EN != 0) state_nxt = PARITY;
            else                state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          bit_cnt_nxt = '0;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        // bit_cnt counts stop bits here so two stop bits need no extra timer
        if (bit_tick) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            frame_done  = 1'b1;
            bit_cnt_nxt = '0;
            if (start_ok) state_nxt = POP;
            else          state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      default: tx_nxt = 1'b1;
    endcase

    baud_clr = (state_nxt != state) || bit_tick;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      parity     <= parity_nxt;
      tx         <= tx_nxt;
      fifo_rd_en <= (state_nxt == POP);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E2 at 4 clocks/bit), each
// fed by a behavioural FIFO, with frames compared against an ideal waveform.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] tx_en = 2'b00;
  logic [1:0] wr_en = 2'b00;
  logic [1:0] fifo_empty, rd_en, tx_w, busy_w, done_w;
  logic [7:0] wr_data [2] = '{8'h00, 8'h00};
  logic [7:0] rdata   [2] = '{8'h00, 8'h00};
  logic [7:0] mem     [2][8];
  int         wptr [2] = '{0, 0};
  int         rptr [2] = '{0, 0};
  int         cnt  [2] = '{0, 0};
  int         pops [2] = '{0, 0};
  logic [7:0] sb_a [$];
  logic [7:0] sb_b [$];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(rdata[0]), .fifo_rd_en(rd_en[0]), .tx(tx_w[0]),
    .busy(busy_w[0]), .frame_done(done_w[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(rdata[1]), .fifo_rd_en(rd_en[1]), .tx(tx_w[1]),
    .busy(busy_w[1]), .frame_done(done_w[1]));

  // Behavioural 8-entry FIFOs; they keep their contents across DUT resets.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k] && cnt[k] > 0) begin
        rdata[k] <= mem[k][rptr[k]];
        rptr[k]  <= (rptr[k] + 1) % 8;
      end
      if (wr_en[k] && cnt[k] < 8) begin
        mem[k][wptr[k]] <= wr_data[k];
        wptr[k]         <= (wptr[k] + 1) % 8;
      end
      cnt[k] <= cnt[k] + ((wr_en[k] && cnt[k] < 8) ? 1 : 0)
                       - ((rd_en[k] && cnt[k] > 0) ? 1 : 0);
      if (rd_en[k]) pops[k] <= pops[k] + 1;
    end
  end

  assign fifo_empty[0] = (cnt[0] == 0);
  assign fifo_empty[1] = (cnt[1] == 0);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Ideal line waveform, one entry per clock, starting at the start bit.
  function automatic int build_frame(input logic [7:0] b, input int par, input int stops,
                                     output logic [63:0] wave);
    logic bits [$];
    int   idx;
    int   ones;
    idx  = 0;
    ones = 0;
    wave = '1;
    bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) begin
      bits.push_back(b[j]);
      ones += int'(b[j]);
    end
    if (par != 0) bits.push_back(ones % 2 == 1);
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < CPB; c++) begin
        wave[idx] = bits[i];
        idx++;
      end
    end
    return idx;
  endfunction

  task automatic push(input int k, input logic [7:0] b);
    wr_en[k]   = 1'b1;
    wr_data[k] = b;
    @(negedge clk);
    wr_en[k] = 1'b0;
    if (k == 0) sb_a.push_back(b);
    else        sb_b.push_back(b);
  endtask

  task automatic wait_start(input int k, output int waited);
    waited = 0;
    while (tx_w[k] !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (tx_w[k] !== 1'b0) check_eq("start_timeout", 64'(tx_w[k]), 64'd0);
  endtask

  task automatic check_frame(input int k, input string tag, input int drop_at);
    logic [63:0] exp_w, got_w, got_d;
    logic [7:0]  b;
    int          len;
    if (k == 0) b = sb_a.pop_front();
    else        b = sb_b.pop_front();
    len   = build_frame(b, k, k + 1, exp_w);
    got_w = '1;
    got_d = '0;
    for (int i = 0; i < len; i++) begin
      if (i == drop_at) tx_en[k] = 1'b0;
      got_w[i] = tx_w[k];
      got_d[i] = done_w[k];
      if (i == len - 1) check_eq({tag, "_busy_last"}, 64'(busy_w[k]), 64'd1);
      @(negedge clk);
    end
    check_eq({tag, "_wave"}, got_w, exp_w);
    check_eq({tag, "_done"}, got_d, 64'd1 << (len - 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w, p0, k, n;
    logic [1:0] any_rd, any_busy, all_tx;

    repeat (3) @(negedge clk);
    check_eq("rst_tx",    64'(tx_w),   64'h3);
    check_eq("rst_busy",  64'(busy_w), 64'h0);
    check_eq("rst_rd_en", 64'(rd_en),  64'h0);
    check_eq("rst_done",  64'(done_w), 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // empty FIFOs with tx_en high
    tx_en    = 2'b11;
    any_rd   = '0;
    any_busy = '0;
    all_tx   = '1;
    repeat (100) begin
      @(negedge clk);
      any_rd   |= rd_en;
      any_busy |= busy_w;
      all_tx   &= tx_w;
    end
    check_eq("empty_rd_en", 64'(any_rd),   64'h0);
    check_eq("empty_busy",  64'(any_busy), 64'h0);
    check_eq("empty_tx",    64'(all_tx),   64'h3);

    // single byte 0xA5, including pop latency
    p0 = pops[0];
    push(0, 8'hA5);
    check_eq("a5_rd_en_pre", 64'(rd_en[0]), 64'd0);
    @(negedge clk);
    check_eq("a5_rd_en", 64'(rd_en[0]), 64'd1);
    wait_start(0, w);
    check_eq("a5_start_lat", 64'(w), 64'd2);
    check_frame(0, "a5", -1);
    check_eq("a5_busy_fall", 64'(busy_w[0]), 64'd0);
    repeat (5) @(negedge clk);
    check_eq("a5_pops", 64'(pops[0] - p0), 64'd1);

    // back-to-back 0x00 then 0xFF
    p0 = pops[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_start(0, w);
    check_frame(0, "b2b0", -1);
    wait_start(0, w);
    check_eq("b2b_gap", 64'(w), 64'd2);
    check_frame(0, "b2b1", -1);
    repeat (5) @(negedge clk);
    check_eq("b2b_pops", 64'(pops[0] - p0), 64'd2);

    // even parity, two stop bits
    push(1, 8'h07);
    wait_start(1, w);
    check_frame(1, "par07", -1);

    // tx_en dropped during data bit 3 with a second byte queued
    push(0, 8'h3C);
    push(0, 8'h81);
    wait_start(0, w);
    check_frame(0, "txen0", 4 * CPB + 1);
    p0 = pops[0];
    repeat (20) @(negedge clk);
    check_eq("txen_nopop", 64'(pops[0] - p0), 64'd0);
    check_eq("txen_idle",  64'(busy_w[0]), 64'd0);
    tx_en[0] = 1'b1;
    @(negedge clk);
    check_eq("txen_pop_lat", 64'(rd_en[0]), 64'd1);
    wait_start(0, w);
    check_eq("txen_start_lat", 64'(w), 64'd2);
    check_frame(0, "txen1", -1);

    // asynchronous reset mid-DATA; the popped byte is lost
    push(0, 8'h5A);
    push(0, 8'hC3);
    wait_start(0, w);
    repeat (14) @(negedge clk);
    check_eq("pre_rst_tx", 64'(tx_w[0]), 64'd0);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_tx",    64'(tx_w[0]),   64'd1);
    check_eq("mid_rst_busy",  64'(busy_w[0]), 64'd0);
    check_eq("mid_rst_rd_en", 64'(rd_en[0]),  64'd0);
    void'(sb_a.pop_front());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_start(0, w);
    check_frame(0, "post_rst", -1);

    // randomized bursts on either instance
    repeat (8) begin
      k  = int'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 3));
      p0 = pops[k];
      for (int j = 0; j < n; j++) push(k, 8'($urandom));
      for (int j = 0; j < n; j++) begin
        wait_start(k, w);
        check_frame(k, "rnd", -1);
      end
      repeat (4) @(negedge clk);
      check_eq("rnd_pops", 64'(pops[k] - p0), 64'(n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
